branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, compared-operand width.
REQ-002 SHALL have parameter ADDR_W, default 64, PC/target width.
REQ-003 SHALL have parameter FLUSH_DEPTH, default 2, flush cycles per taken branch (0..15).
REQ-004 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-005 SHALL have one clock, `clock`, and `reset`, which is synchronous and active-high.
REQ-006 Ports, in order: `clock` in 1, rising-edge clock; `reset` in 1, synchronous active-high reset.
REQ-007 Ports: `in_valid` in 1, branch offered; `in_ready` out 1, unit accepts.
REQ-008 Ports: `op` in 2 (00 CBZ, 01 CBNZ, 10 B, 11 B.cond); `cond` in 4, ARMv8 condition code; `nzcv` in 4, flags.
REQ-009 Ports: `operand` in DATA_W, register tested; `pc` in ADDR_W; `offset` in ADDR_W, signed byte offset, pre-shifted.
REQ-010 Ports: `redirect_valid` out 1; `redirect_ready` in 1; `redirect_pc` out ADDR_W; `flush` out 1; `busy` out 1.
REQ-011 Ports, only with BRANCH_STATS_EN: `taken_count` out CNT_W; `nottaken_count` out CNT_W.

Function
REQ-012 Accept: a branch is accepted on a rising edge where in_valid && in_ready.
REQ-013 in_ready SHALL be 1 only in state IDLE; busy SHALL equal !in_ready.
REQ-014 Taken rules:
- CBZ: taken when operand==0.
- CBNZ: taken when operand!=0.
- B: always taken.
- B.cond: taken per the ARMv8 EQ..LE table on nzcv; AL (1110) and NV (1111) both taken.
REQ-015 Target: pc+offset SHALL be computed modulo 2^ADDR_W; the carry out is discarded.
REQ-016 States SHALL be IDLE, REDIRECT and FLUSH.
REQ-017 Taken branch accepted in IDLE:
- redirect_pc registers the target.
- State goes to REDIRECT.
- redirect_valid=1 from the next cycle.
REQ-018 A not-taken branch SHALL leave the state at IDLE, assert no output, and keep in_ready=1, allowing back-to-back acceptance.
REQ-019 REDIRECT: redirect_valid and redirect_pc SHALL be held stable until redirect_ready=1 on a clock edge, with no timeout.
REQ-020 On the redirect handshake edge, the next state SHALL be:
- FLUSH_DEPTH>0: FLUSH, with the flush counter loaded to FLUSH_DEPTH.
- FLUSH_DEPTH=0: IDLE.
REQ-021 FLUSH: flush=1 for exactly FLUSH_DEPTH consecutive cycles, then IDLE; redirect_valid=0 throughout.
REQ-022 in_valid outside IDLE SHALL be ignored, with no effect on state, outputs or counters.
REQ-023 Latency: an accept edge SHALL be followed by redirect_valid one cycle later and the first flush cycle one cycle after the handshake edge.

Reset
REQ-024 When reset=1 on a clock edge, outputs SHALL become:
- state IDLE.
- redirect_valid=0, flush=0.
- redirect_pc=0.
- in_ready=1, busy=0.
- counters=0.
REQ-025 Reset SHALL take priority over any simultaneous accept or handshake.
REQ-026 Reset mid-REDIRECT or mid-FLUSH SHALL abort the sequence; no further flush cycles occur.

Configuration
REQ-027 With BRANCH_STATS_EN defined:
- taken_count increments on each accepted taken branch.
- nottaken_count increments on each accepted not-taken branch.
- Both saturate at 2^CNT_W-1 and do not wrap.
REQ-028 Without BRANCH_STATS_EN, the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 CBZ, operand=1, pc=0x04, offset=24 -> not taken; redirect_valid stays 0; in_ready=1 the next cycle; nottaken_count=1.
REQ-030 CBZ, operand=0, pc=0x0C, offset=16, redirect_ready=1 -> redirect_pc=0x1C for one cycle, then flush=1 for 2 cycles, then IDLE.
REQ-031 CBNZ, operand=1, pc=0x30, offset=16, redirect_ready held 0 for 3 cycles -> redirect_valid=1 with redirect_pc=0x40 stable for 4 cycles; in_valid pulses ignored.
REQ-032 B, pc=0xFFFF_FFFF_FFFF_FFF8, offset=16 -> redirect_pc=0x8 (wrap-around).
REQ-033 B.cond GE with nzcv=1001 -> taken; with nzcv=1000 -> not taken.
REQ-034 Reset asserted in the first FLUSH cycle -> next cycle flush=0, in_ready=1, taken_count=0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves one branch at a time. If the branch is taken, the unit holds a
// redirect request until the front end acknowledges it. It then flushes the
// pipeline for FLUSH_DEPTH cycles before it accepts the next branch.
//
// Optional feature macro: BRANCH_STATS_EN (adds taken/not-taken counters).
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   branch offer / unit can accept (ready only in IDLE)
//   op                  00 CBZ, 01 CBNZ, 10 B, 11 B.cond
//   cond, nzcv          ARMv8 condition code and flags {N,Z,C,V}
//   operand             register tested by CBZ/CBNZ
//   pc, offset          branch address and signed, pre-shifted byte offset
//   redirect_valid/_ready/_pc  redirect request to the front end
//   flush               pipeline flush strobe, FLUSH_DEPTH cycles per branch
//   busy                inverse of in_ready
//   taken_count, nottaken_count  saturating statistics (BRANCH_STATS_EN only)
//   dbg_state           current FSM state for checkers
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. A valid signal, once raised, keeps its payload stable
// until that edge, and it never waits on ready combinationally.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [3:0]        cond,
  input  logic [3:0]        nzcv,
  input  logic [DATA_W-1:0] operand,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] offset,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  taken_count,
  output logic [CNT_W-1:0]  nottaken_count
`endif
  ,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam logic [1:0] OP_CBZ  = 2'b00;
  localparam logic [1:0] OP_CBNZ = 2'b01;
  localparam logic [1:0] OP_B    = 2'b10;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;
  logic taken;
  logic accept;

  assign flag_n = nzcv[3];
  assign flag_z = nzcv[2];
  assign flag_c = nzcv[1];
  assign flag_v = nzcv[0];

  // ARMv8 condition table. AL and NV both count as always-true here.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;                               // EQ
      4'h1: cond_pass = !flag_z;                              // NE
      4'h2: cond_pass = flag_c;                               // CS
      4'h3: cond_pass = !flag_c;                              // CC
      4'h4: cond_pass = flag_n;                               // MI
      4'h5: cond_pass = !flag_n;                              // PL
      4'h6: cond_pass = flag_v;                               // VS
      4'h7: cond_pass = !flag_v;                              // VC
      4'h8: cond_pass = flag_c && !flag_z;                    // HI
      4'h9: cond_pass = !(flag_c && !flag_z);                 // LS
      4'hA: cond_pass = (flag_n == flag_v);                   // GE
      4'hB: cond_pass = (flag_n != flag_v);                   // LT
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);        // GT
      4'hD: cond_pass = flag_z || (flag_n != flag_v);         // LE
      default: cond_pass = 1'b1;                              // AL, NV
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_CBZ:  taken = (operand == '0);
      OP_CBNZ: taken = (operand != '0);
      OP_B:    taken = 1'b1;
      default: taken = cond_pass;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = !in_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    flush_cnt_d   = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && taken) begin
          // Adding at ADDR_W bits drops the carry, so the target wraps modulo 2^ADDR_W.
          redirect_pc_d = pc + offset;
          state_d       = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_DEPTH > 0) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        // The counter holds the flush cycles that remain, this cycle included.
        if (flush_cnt_q <= 4'd1) begin
          state_d     = IDLE;
          flush_cnt_d = 4'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      flush_cnt_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign flush          = (state_q == FLUSH);
  assign dbg_state      = state_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic [CNT_W-1:0] nottaken_count_q, nottaken_count_d;

  // Both counters saturate at all-ones and do not wrap.
  always_comb begin
    taken_count_d    = taken_count_q;
    nottaken_count_d = nottaken_count_q;
    if (accept) begin
      if (taken) begin
        if (taken_count_q != '1) taken_count_d = taken_count_q + 1'b1;
      end else begin
        if (nottaken_count_q != '1) nottaken_count_d = nottaken_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      taken_count_q    <= '0;
      nottaken_count_q <= '0;
    end else begin
      taken_count_q    <= taken_count_d;
      nottaken_count_q <= nottaken_count_d;
    end
  end

  assign taken_count    = taken_count_q;
  assign nottaken_count = nottaken_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Self-checking bench for branch_resolve_unit. Each taken branch pushes its
// expected target into a queue. The entry is popped and compared when the
// redirect handshake is seen. Not-taken behaviour, redirect hold, flush
// length, reset abort and the optional counters are checked directly.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int FD = 2;
  localparam int CW = 4;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [3:0]    cond;
  logic [3:0]    nzcv;
  logic [DW-1:0] operand;
  logic [AW-1:0] pc;
  logic [AW-1:0] offset;
  logic          redirect_valid;
  logic          redirect_ready;
  logic [AW-1:0] redirect_pc;
  logic          flush;
  logic          busy;
  logic [1:0]    dbg_state;
`ifdef BRANCH_STATS_EN
  logic [CW-1:0] taken_count;
  logic [CW-1:0] nottaken_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];
  int exp_taken    = 0;
  int exp_nottaken = 0;

  branch_resolve_unit #(
    .DATA_W(DW), .ADDR_W(AW), .FLUSH_DEPTH(FD), .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .cond(cond),
    .nzcv(nzcv),
    .operand(operand),
    .pc(pc),
    .offset(offset),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .busy(busy)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count(taken_count),
    .nottaken_count(nottaken_count)
`endif
    ,
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change, and outputs are sampled, 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model. It evaluates the base condition on cond[3:1], and an odd
  // code inverts the result, except code 1111.
  function automatic logic model_taken(input logic [1:0] o, input logic [3:0] c,
                                       input logic [3:0] f, input logic [DW-1:0] v);
    logic n, z, cy, ov, base;
    n = f[3]; z = f[2]; cy = f[1]; ov = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = ov;
      3'd4: base = cy & ~z;
      3'd5: base = (n == ov);
      3'd6: base = ~z & (n == ov);
      default: base = 1'b1;
    endcase
    if (c[0] && (c != 4'hF)) base = ~base;
    case (o)
      2'b00:   return (v == 0);
      2'b01:   return (v != 0);
      2'b10:   return 1'b1;
      default: return base;
    endcase
  endfunction

  task automatic check_counters(input string tag);
`ifdef BRANCH_STATS_EN
    check({tag, "_taken_cnt"}, 64'(taken_count), 64'(exp_taken));
    check({tag, "_nt_cnt"}, 64'(nottaken_count), 64'(exp_nottaken));
`else
    check({tag, "_idle_state"}, 64'(dbg_state), 64'd0);
`endif
  endtask

  // Drives an offered branch that the unit should ignore (outside IDLE).
  task automatic drive_garbage();
    in_valid = 1'($urandom_range(0, 1));
    op       = 2'b10;
    pc       = {$urandom, $urandom};
    offset   = {$urandom, $urandom};
  endtask

  // Drives one branch in IDLE and follows it to IDLE again. hold is the
  // number of cycles that redirect_ready stays low.
  task automatic run_branch(input logic [1:0] b_op, input logic [3:0] b_cond,
                            input logic [3:0] b_nzcv, input logic [DW-1:0] b_operand,
                            input logic [AW-1:0] b_pc, input logic [AW-1:0] b_off,
                            input int hold);
    logic tk;
    tk = model_taken(b_op, b_cond, b_nzcv, b_operand);
    op = b_op; cond = b_cond; nzcv = b_nzcv; operand = b_operand;
    pc = b_pc; offset = b_off; in_valid = 1'b1; redirect_ready = 1'b0;
    if (tk) begin
      exp_q.push_back(b_pc + b_off);
      if (exp_taken < (2 ** CW) - 1) exp_taken++;
    end else begin
      if (exp_nottaken < (2 ** CW) - 1) exp_nottaken++;
    end
    step();
    in_valid = 1'b0;
    if (!tk) begin
      check("nt_redirect_valid", 64'(redirect_valid), 64'd0);
      check("nt_in_ready", 64'(in_ready), 64'd1);
      check("nt_flush", 64'(flush), 64'd0);
      return;
    end
    for (int i = 0; i <= hold; i++) begin
      check("rd_valid", 64'(redirect_valid), 64'd1);
      check("rd_busy", 64'(busy), 64'd1);
      if (exp_q.size() == 0) begin
        check("rd_sb_empty", 64'd1, 64'd0);
      end else if (i == hold) begin
        check("rd_pc", redirect_pc, exp_q.pop_front());
      end else begin
        check("rd_pc_hold", redirect_pc, exp_q[0]);
      end
      redirect_ready = (i == hold);
      drive_garbage();
      step();
    end
    redirect_ready = 1'b0;
    for (int i = 0; i < FD; i++) begin
      check("fl_on", 64'(flush), 64'd1);
      check("fl_no_redirect", 64'(redirect_valid), 64'd0);
      check("fl_ready", 64'(in_ready), 64'd0);
      drive_garbage();
      step();
    end
    in_valid = 1'b0;
    check("fl_done", 64'(flush), 64'd0);
    check("back_idle_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; redirect_ready = 1'b0;
    op = 2'b00; cond = 4'h0; nzcv = 4'h0; operand = '0; pc = '0; offset = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check_counters("rst");

    // CBZ on a nonzero operand: not taken
    run_branch(2'b00, 4'h0, 4'h0, 64'd1, 64'h04, 64'd24, 0);
    check_counters("cbz_nt");

    // CBZ on zero: taken to 0x1C, with immediate ready
    run_branch(2'b00, 4'h0, 4'h0, 64'd0, 64'h0C, 64'd16, 0);

    // CBNZ taken to 0x40, ready held low for 3 cycles
    run_branch(2'b01, 4'h0, 4'h0, 64'd1, 64'h30, 64'd16, 3);

    // B with a wrapping target
    run_branch(2'b10, 4'h0, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd16, 1);

    // B.cond GE: taken with N=V, not taken with N!=V
    run_branch(2'b11, 4'hA, 4'b1001, 64'd0, 64'h100, 64'h40, 0);
    run_branch(2'b11, 4'hA, 4'b1000, 64'd0, 64'h200, 64'h40, 0);
    // Back-to-back not-taken accepts
    run_branch(2'b01, 4'h0, 4'h0, 64'd0, 64'h300, 64'h8, 0);
    // NV is treated as always taken, and the offset is negative
    run_branch(2'b11, 4'hF, 4'h0, 64'd0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 2);
    check_counters("directed");

    // Random branches. There are enough of them to saturate the 4-bit counters.
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] v;
      v = ($urandom_range(0, 1) == 0) ? '0 : {$urandom, $urandom};
      run_branch(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), v, {$urandom, $urandom},
                 {$urandom, $urandom}, $urandom_range(0, 3));
    end
    check_counters("random");

    // Reset in the first flush cycle aborts the sequence
    op = 2'b00; operand = '0; pc = 64'h50; offset = 64'h10; in_valid = 1'b1;
    exp_q.push_back(64'h60);
    step();
    in_valid = 1'b0;
    redirect_ready = 1'b1;
    check("ab_rd_pc", redirect_pc, exp_q.pop_front());
    step();
    redirect_ready = 1'b0;
    check("ab_first_flush", 64'(flush), 64'd1);
    // Reset also wins over a simultaneous taken offer
    reset = 1'b1; in_valid = 1'b1; op = 2'b10;
    step();
    reset = 1'b0; in_valid = 1'b0;
    exp_taken = 0; exp_nottaken = 0;
    check("ab_flush_off", 64'(flush), 64'd0);
    check("ab_in_ready", 64'(in_ready), 64'd1);
    check("ab_redirect_valid", 64'(redirect_valid), 64'd0);
    check("ab_redirect_pc", redirect_pc, 64'd0);
    check_counters("ab");
    step();
    check("ab_no_more_flush", 64'(flush), 64'd0);

    // Reset with a taken offer while IDLE: the accept is suppressed
    reset = 1'b1; in_valid = 1'b1; op = 2'b10;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check("rp_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rp_in_ready", 64'(in_ready), 64'd1);
    check_counters("rp");

    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
